// File: rtl/dac_spi_writer_pkg.sv
// Shared definitions for the DAC serial writer.
// Holds the FSM state encoding, the frame width, the code width the frame is
// built around, and the power-down mode codes carried in frame bits [13:12].
package dac_spi_writer_pkg;

    localparam int FRAME_W = 16;
    // Widest supported DAC code; narrower codes are left-aligned in this field.
    localparam int CODE_W  = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/dac_spi_writer_sclk_gen.sv
// SCLK generator for the DAC serial writer.
// Counts DIV clk_in cycles per SCLK half-period while enabled and toggles the
// SCLK level at the end of every half-period. While disabled SCLK is held high
// and the counter is cleared, so every frame starts with a full high phase.
// Ports:
//   clk_in  in   system clock
//   rst_n   in   asynchronous active-low reset
//   en      in   run the half-period counter
//   tick    out  last cycle of the current half-period (SCLK toggles next edge)
//   sclk    out  registered SCLK level
module dac_sclk_gen #(
    parameter int DIV = 1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    output logic tick,
    output logic sclk
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// Serial writer for a DAC081S101/DAC101S101/DAC121S101-class 3-wire DAC.
// Accepts one parallel code per start/ready handshake and sends it as a
// 16-bit frame {2'b00, pd, din, zero pad}, MSB first, with SCLK = clk_in/(2*DIV).
// Handshake: a frame is accepted on a clk_in rising edge where start && ready;
// ready is high only while idle, and start while busy is dropped, not queued.
// Ports:
//   clk_in  in   system clock
//   rst_n   in   asynchronous active-low reset
//   start   in   frame request
//   pd      in   power-down mode for the frame
//   din     in   DAC code, captured at acceptance
//   ready   out  idle, may accept a frame
//   busy    out  inverse of ready
//   done    out  one-cycle pulse once the frame and SYNC high time complete
//   sync_n  out  DAC SYNC, active low
//   sclk    out  DAC SCLK, idles high
//   sdo     out  DAC DIN, changes only on SCLK rising edges
module dac_spi_writer
    import dac_spi_writer_pkg::*;
#(
    parameter int DIV         = 1,
    parameter int T_SYNC_HIGH = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        pd,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              sync_n,
    output logic              sclk,
    output logic              sdo
);

    localparam int HW = (T_SYNC_HIGH > 1) ? $clog2(T_SYNC_HIGH) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(T_SYNC_HIGH - 1);

    state_t             state;
    state_t             next_state;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame;
    logic [CODE_W-1:0]  code;
    logic [3:0]         bit_cnt;
    logic [HW-1:0]      hold_cnt;
    logic               tick;
    logic               sclk_en;
    logic               accept;
    logic               rise_evt;
    logic               last_bit;
    logic               ready_d;
    logic               done_d;
    logic               sync_n_d;
    logic               sdo_d;

    // Narrow codes sit left-aligned in the 12-bit field with zero padding below.
    assign code  = CODE_W'(din) << (CODE_W - DATA_W);
    assign frame = {2'b00, pd, code};

    assign accept  = (state == ST_IDLE) && start;
    // SETUP is the first SCLK high phase, so the generator runs from SETUP on.
    assign sclk_en = (state == ST_SETUP) || (state == ST_SHIFT);
    // A tick while SCLK is low ends a low phase: SCLK rises on the next edge.
    assign rise_evt = (state == ST_SHIFT) && tick && !sclk;
    assign last_bit = (bit_cnt == 4'd15);

    dac_sclk_gen #(
        .DIV (DIV)
    ) u_sclk_gen (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (sclk_en),
        .tick   (tick),
        .sclk   (sclk)
    );

    // State register and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            sync_n <= 1'b1;
            sdo    <= 1'b0;
        end else begin
            state  <= next_state;
            ready  <= ready_d;
            busy   <= ~ready_d;
            done   <= done_d;
            sync_n <= sync_n_d;
            sdo    <= sdo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start)                     next_state = ST_SETUP;
            ST_SETUP: if (tick)                      next_state = ST_SHIFT;
            // The 16th low phase ends with SYNC rising instead of a high phase.
            ST_SHIFT: if (rise_evt && last_bit)      next_state = ST_HOLD;
            ST_HOLD:  if (hold_cnt == HOLD_LAST)     next_state = ST_IDLE;
            default:                                 next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        ready_d  = (next_state == ST_IDLE);
        done_d   = (state == ST_HOLD) && (next_state == ST_IDLE);
        sync_n_d = !((next_state == ST_SETUP) || (next_state == ST_SHIFT));
        sdo_d    = 1'b0;
        case (next_state)
            ST_SETUP: sdo_d = (state == ST_IDLE) ? frame[FRAME_W-1] : sdo;
            ST_SHIFT: sdo_d = rise_evt ? shreg[FRAME_W-2] : sdo;
            default:  sdo_d = 1'b0;
        endcase
    end

    // Shift register, bit counter and SYNC high-time counter.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (accept) begin
                shreg   <= frame;
                bit_cnt <= '0;
            end else if (rise_evt && !last_bit) begin
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

endmodule
